array_cmd_seq: RTL
==================

// Module: array_cmd_seq
// PURPOSE
//  Host-side command sequencer; the initiator that drives array_ctrl's op_code/addr_bank/addr_col/data.
//  Accepts host requests over valid/ready and holds each array op stable for its required cycles.
//  Expands burst writes across consecutive banks.
//  Captures read/search results from the array and returns them to the host over valid/ready.
// PARAMETERS
//  DATA_W   16  data/result width
//  BANK_W   4   bank address width (16 banks)
//  COL_W    3   column address width (8 cols)
//  ARR_LAT  2   cycles read/search op is held before arr_rdata is valid (>=1)
//  WR_CYC   1   cycles write op is held per beat (>=1)
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       async active-low reset
//  req_valid  in   1       host request valid
//  req_ready  out  1       sequencer accepts request/beat
//  req_op     in   2       00 read, 01 write, 10 search, 11 nop
//  req_bank   in   BANK_W  start bank (write only)
//  req_col    in   COL_W   search column
//  req_len    in   4       write burst beats minus 1 (ignored for read/search)
//  req_data   in   DATA_W  read bias / write word / search query
//  op_code    out  2       to array_ctrl
//  addr_bank  out  BANK_W  to array_ctrl
//  addr_col   out  COL_W   to array_ctrl
//  data       out  DATA_W  to array_ctrl (passed unmasked; array_ctrl masks)
//  arr_rdata  in   DATA_W  array result (read/search)
//  rsp_valid  out  1       response valid
//  rsp_ready  in   1       host accepts response
//  rsp_op     out  2       op of this response
//  rsp_data   out  DATA_W  result; for write = beats written, zero-extended
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (async): state IDLE, op_code=2'b11, addr/data=0, rsp_valid=0, rsp_op=0, rsp_data=0, busy=0.
//  States: IDLE, ISSUE, WR_WAIT, RESP.
//  req_ready=1 only in IDLE and WR_WAIT; rsp_valid=1 only in RESP.
//  IDLE: on req_valid&req_ready, register op/addr/data, load hold counter, go ISSUE.
//   - nop request: consumed, no ISSUE, no response.
//  ISSUE: op_code/addr/data stable for the full hold.
//   - read/search: hold ARR_LAT cycles.
//   - write: hold WR_CYC cycles.
//  Read/search latency: accepted at edge T -> op_code valid T+1..T+ARR_LAT.
//   - arr_rdata sampled at the last hold edge; rsp_valid from T+ARR_LAT+1.
//  Write beat done:
//   - If beats remaining: op_code=11, bank+1 (15 wraps to 0), go WR_WAIT.
//   - Else: go RESP with rsp_data=req_len+1.
//  WR_WAIT: req_ready=1.
//   - Next accepted beat takes req_data only; req_op/bank/col/len ignored. Go ISSUE.
//   - No timeout; host stalls indefinitely.
//  RESP: rsp_* held stable until rsp_ready; then IDLE, op_code=11.
//   - New request accepted only next cycle; no overlap.
//  op_code=11 (idle) in every state except ISSUE.
//  Reset mid-op: in-flight op and partial burst abandoned; no response produced.
//  rsp_ready high before rsp_valid has no effect; rsp_valid never drops without handshake.
// STRUCTURE
//  Shared package cim_pkg:
//   - OP_READ=2'b00, OP_WRITE=2'b01, OP_SEARCH=2'b10, OP_IDLE=2'b11
//   - state encoding localparams
//   - BANK_W/COL_W defaults
//  Single module; hold counter and beat counter inline. No sub-module.
// TESTING
//  1. Reset assert mid-ISSUE -> same cycle op_code=11, rsp_valid=0, busy=0; next req accepted normally.
//  2. Read, data=16'h00A5, arr_rdata=16'h1234 in last hold cycle, ARR_LAT=2 -> op_code=00 for 2 cycles; rsp_valid 3 cycles after accept; rsp_data=16'h1234, rsp_op=00.
//  3. Search col=5, data=16'hFFF3 -> addr_col=5, data=16'hFFF3 for ARR_LAT cycles; rsp_op=10 with sampled result.
//  4. Write bank=14, len=2, beats 11/22/33 -> banks 14,15,0 with data 11,22,33; op_code=11 between beats; rsp_data=3.
//  5. Write burst, host stalls 5 cycles in WR_WAIT -> op_code=11 held, addr_bank unchanged, no response until final beat.
//  6. rsp_ready low 4 cycles -> rsp_* stable, req_ready=0; nop request in IDLE -> consumed, no rsp_valid.

Source files
------------

// File: rtl/cim_pkg.sv
// cim_pkg: shared op codes, sequencer states and default widths for the CIM array blocks
package cim_pkg;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SEARCH = 2'b10;
    localparam logic [1:0] OP_IDLE   = 2'b11;

    localparam int DATA_W_DEF = 16;
    localparam int BANK_W_DEF = 4;
    localparam int COL_W_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/array_cmd_seq.sv
// array_cmd_seq: host-side sequencer that holds array ops stable, expands write bursts and returns results
module array_cmd_seq
    import cim_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BANK_W  = BANK_W_DEF,
    parameter int COL_W   = COL_W_DEF,
    parameter int ARR_LAT = 2,
    parameter int WR_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [COL_W-1:0]  req_col,
    input  logic [3:0]        req_len,
    input  logic [DATA_W-1:0] req_data,
    output logic [1:0]        op_code,
    output logic [BANK_W-1:0] addr_bank,
    output logic [COL_W-1:0]  addr_col,
    output logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] arr_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_op,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    localparam logic [7:0] RD_HOLD = 8'(ARR_LAT - 1);
    localparam logic [7:0] WR_HOLD = 8'(WR_CYC - 1);

    seq_state_t state, state_nx;
    logic [1:0] op_r;
    logic [7:0] hold_cnt;
    logic [3:0] beats_left;
    logic [3:0] len_r;
    logic       hold_done;
    logic       new_req;
    logic       next_beat;

    assign hold_done = (hold_cnt == 8'd0);
    assign new_req   = (state == ST_IDLE) && req_valid && (req_op != OP_IDLE);
    assign next_beat = (state == ST_WR_WAIT) && req_valid;
    assign busy      = (state != ST_IDLE);

    // state register; async reset abandons any in-flight op or partial burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // next state and handshake/array outputs; the array sees idle outside ISSUE
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        op_code   = OP_IDLE;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (new_req) state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                op_code = op_r;
                if (hold_done)
                    state_nx = (op_r == OP_WRITE && beats_left != 4'd0) ? ST_WR_WAIT : ST_RESP;
            end
            ST_WR_WAIT: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = ST_ISSUE;
            end
            default: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = ST_IDLE;
            end
        endcase
    end

    // request capture, hold/beat counting, burst bank stepping and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r       <= OP_IDLE;
            addr_bank  <= '0;
            addr_col   <= '0;
            data       <= '0;
            hold_cnt   <= '0;
            beats_left <= '0;
            len_r      <= '0;
            rsp_op     <= OP_READ;
            rsp_data   <= '0;
        end else begin
            if (new_req) begin
                op_r       <= req_op;
                addr_bank  <= req_bank;
                addr_col   <= req_col;
                data       <= req_data;
                len_r      <= req_len;
                beats_left <= req_len;
                hold_cnt   <= (req_op == OP_WRITE) ? WR_HOLD : RD_HOLD;
            end
            if (next_beat) begin
                data     <= req_data;
                hold_cnt <= WR_HOLD;
            end
            if (state == ST_ISSUE) begin
                if (!hold_done) begin
                    hold_cnt <= hold_cnt - 8'd1;
                end else if (op_r != OP_WRITE) begin
                    rsp_op   <= op_r;
                    rsp_data <= arr_rdata;
                end else if (beats_left != 4'd0) begin
                    beats_left <= beats_left - 4'd1;
                    addr_bank  <= addr_bank + BANK_W'(1);
                end else begin
                    rsp_op   <= OP_WRITE;
                    rsp_data <= DATA_W'({1'b0, len_r} + 5'd1);
                end
            end
        end
    end

endmodule
